ser_data_receiver: RTL and testbench

SER_DATA_RECEIVER -- requirements
Module: ser_data_receiver

---
 rtl/ser_data_pkg.sv | 37 +++
 rtl/ser_bit_sampler.sv | 59 +++++
 rtl/ser_data_receiver.sv | 126 ++++++++++++
 tb/tb_ser_data_receiver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ser_data_pkg.sv
// ============================================================================
// ser_data_pkg : shared timing constants, state encoding and helpers
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ser_data_pkg;

    localparam int c_DEF_CLKS_PER_BIT = 50;
    localparam int c_DEF_DATA_W       = 8;

    // Sample offsets relative to the bit centre (CLKS_PER_BIT/2)
    localparam int c_SAMPLE_OFS_EARLY = -1;
    localparam int c_SAMPLE_OFS_MID   = 0;
    localparam int c_SAMPLE_OFS_LATE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int frame_len(input int cpb, input int dw);
        return cpb * dw;
    endfunction

    function automatic int sample_point(input int cpb, input int bit_idx, input int ofs);
        return bit_idx * cpb + cpb / 2 + ofs;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_bit_sampler.sv
// ============================================================================
// ser_bit_sampler : 3-point bit-centre sampling with 2-of-3 majority vote
// Revision        : 1.0
// ============================================================================
`default_nettype none

module ser_bit_sampler
    import ser_data_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int CNT_W        = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             rx_s_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             bit_o,
    output logic             bit_valid_o
);

    logic w_at_early;
    logic w_at_mid;
    logic w_at_late;
    logic early_q;
    logic mid_q;

    always_comb begin
        w_at_early = 1'b0;
        w_at_mid   = 1'b0;
        w_at_late  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_i == CNT_W'(sample_point(CLKS_PER_BIT, i, c_SAMPLE_OFS_EARLY)))
                w_at_early = 1'b1;
            if (cnt_i == CNT_W'(sample_point(CLKS_PER_BIT, i, c_SAMPLE_OFS_MID)))
                w_at_mid = 1'b1;
            if (cnt_i == CNT_W'(sample_point(CLKS_PER_BIT, i, c_SAMPLE_OFS_LATE)))
                w_at_late = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            early_q <= 1'b0;
            mid_q   <= 1'b0;
        end else if (en_i) begin
            if (w_at_early) early_q <= rx_s_i;
            if (w_at_mid)   mid_q   <= rx_s_i;
        end
    end

    // The third sample is the live value, so the vote resolves on the late point
    assign bit_o       = maj3(early_q, mid_q, rx_s_i);
    assign bit_valid_o = en_i & w_at_late;

endmodule

`default_nettype wire

// File: rtl/ser_data_receiver.sv
// ============================================================================
// ser_data_receiver : en-framed serial receiver with majority sampling
// Revision          : 1.0
// ============================================================================
`default_nettype none

module ser_data_receiver
    import ser_data_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_DEF_CLKS_PER_BIT,
    parameter int DATA_W       = c_DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_done,
    output logic              overrun
);

    localparam int c_FRAME_LEN = frame_len(CLKS_PER_BIT, DATA_W);
    localparam int c_CNT_W     = (c_FRAME_LEN > 1) ? $clog2(c_FRAME_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_LEN - 1);

    state_t              state_q;
    state_t              state_d;
    logic                rx_meta_q;
    logic                rx_s_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                rx_done_q;
    logic                overrun_q;
    logic                w_frame_end;
    logic                w_bit;
    logic                w_bit_valid;

    ser_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_W       (DATA_W),
        .CNT_W        (c_CNT_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .rx_s_i      (rx_s_q),
        .cnt_i       (cnt_q),
        .bit_o       (w_bit),
        .bit_valid_o (w_bit_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            if (!en || cnt_q == c_CNT_LAST)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + c_CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        w_frame_end = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_RECV;
                ST_RECV: begin
                    if (cnt_q == c_CNT_LAST) begin
                        state_d     = ST_DONE;
                        w_frame_end = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_RECV;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Clearing on en low discards any partial frame
    always_ff @(posedge clk) begin
        if (rst || !en)
            shift_q <= '0;
        else if (w_bit_valid)
            shift_q <= {w_bit, shift_q[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_done_q <= w_frame_end;
            overrun_q <= w_frame_end & rx_valid_q & ~rx_ready;
            if (w_frame_end) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_done  = rx_done_q;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ser_data_receiver.sv
// ============================================================================
// tb_ser_data_receiver : directed bench with an en-aligned transmitter model
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_ser_data_receiver;
    import ser_data_pkg::*;

    localparam int CPB  = 50;
    localparam int DW   = 8;
    localparam int FLEN = CPB * DW;

    typedef struct {
        logic [7:0] data;
        int         glitch;
        logic [7:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          rx;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_done;
    logic          overrun;

    int         checks     = 0;
    int         errors     = 0;
    int         tcnt       = 0;
    int         glitch_at  = -1;
    int         cyc        = 0;
    int         done_cnt   = 0;
    int         ovr_cnt    = 0;
    int         first_done = 0;
    logic [7:0] tx_byte    = 8'h00;
    logic [7:0] next_byte  = 8'h00;
    vec_t       vecs[6];

    ser_data_receiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rx       (rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_done  (rx_done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: holds bit tcnt/CPB of tx_byte, idles high when en is low
    task automatic tick();
        rx = (!en) ? 1'b1 : (tcnt == glitch_at) ? 1'b0 : tx_byte[tcnt / CPB];
        @(posedge clk);
        #1;
        if (rst || !en) begin
            tcnt = 0;
        end else if (tcnt == FLEN - 1) begin
            tcnt    = 0;
            tx_byte = next_byte;
        end else begin
            tcnt++;
        end
        cyc++;
        if (rx_done) begin
            done_cnt++;
            first_done = cyc;
        end
        if (overrun) ovr_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start_frame(input logic [7:0] b, input logic [7:0] nb);
        tx_byte   = b;
        next_byte = nb;
        tcnt      = 0;
        en        = 1'b1;
    endtask

    initial begin
        int done1;

        // Glitch on rx at tcnt 223 shows up on the synchronised line at cnt 225
        vecs[0] = '{data: 8'hA5, glitch: -1,  exp: 8'hA5};
        vecs[1] = '{data: 8'h00, glitch: -1,  exp: 8'h00};
        vecs[2] = '{data: 8'hFF, glitch: 223, exp: 8'hFF};
        vecs[3] = '{data: 8'h81, glitch: -1,  exp: 8'h81};
        vecs[4] = '{data: 8'h5A, glitch: -1,  exp: 8'h5A};
        vecs[5] = '{data: 8'h01, glitch: -1,  exp: 8'h01};

        rst = 1'b1; en = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        run(3);
        check("reset_data",    rx_data,  0);
        check("reset_valid",   rx_valid, 0);
        check("reset_done",    rx_done,  0);
        check("reset_overrun", overrun,  0);
        rst = 1'b0;
        run(2);

        for (int i = 0; i < 6; i++) begin
            glitch_at = vecs[i].glitch;
            rx_ready  = 1'b1;
            done_cnt  = 0;
            start_frame(vecs[i].data, vecs[i].data);
            run(FLEN - 1);
            check($sformatf("vec%0d_no_early_done", i), done_cnt, 0);
            tick();
            check($sformatf("vec%0d_done_401", i), rx_done, 1);
            check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), rx_valid, 1);
            en = 1'b0;
            glitch_at = -1;
            tick();
            check($sformatf("vec%0d_done_pulse", i), rx_done, 0);
            check($sformatf("vec%0d_valid_consumed", i), rx_valid, 0);
            run(3);
        end

        // Back-to-back frames with en held high
        rx_ready = 1'b1; done_cnt = 0; ovr_cnt = 0;
        start_frame(8'h3C, 8'hC3);
        run(FLEN);
        check("b2b_done1", rx_done, 1);
        check("b2b_data1", rx_data, 8'h3C);
        done1 = cyc;
        run(FLEN - 1);
        check("b2b_no_mid_done", rx_done, 0);
        tick();
        check("b2b_done2", rx_done, 1);
        check("b2b_data2", rx_data, 8'hC3);
        check("b2b_spacing", first_done - done1, FLEN);
        en = 1'b0;
        tick();
        check("b2b_done_count", done_cnt, 2);
        check("b2b_no_overrun", ovr_cnt, 0);
        run(2);

        // Abort mid-frame leaves the held frame untouched
        rx_ready = 1'b0;
        start_frame(8'h66, 8'h66);
        run(FLEN);
        check("abort_pre_data", rx_data, 8'h66);
        en = 1'b0;
        tick();
        done_cnt = 0;
        start_frame(8'h55, 8'h55);
        run(200);
        en = 1'b0;
        run(FLEN + 10);
        check("abort_no_done", done_cnt, 0);
        check("abort_data", rx_data, 8'h66);
        check("abort_valid", rx_valid, 1);
        check("abort_idle", dut.state_q, ST_IDLE);
        rx_ready = 1'b1;
        tick();
        check("abort_consumed", rx_valid, 0);
        rx_ready = 1'b0;
        run(2);

        // Overrun with consumer stalled
        ovr_cnt = 0;
        start_frame(8'h12, 8'h34);
        run(FLEN);
        check("ovr_data1", rx_data, 8'h12);
        check("ovr_valid1", rx_valid, 1);
        check("ovr_none_first", overrun, 0);
        run(FLEN);
        check("ovr_pulse", overrun, 1);
        check("ovr_data2", rx_data, 8'h34);
        check("ovr_valid2", rx_valid, 1);
        en = 1'b0;
        tick();
        check("ovr_pulse_width", overrun, 0);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        check("ovr_valid_cleared", rx_valid, 0);
        rx_ready = 1'b0;
        tick();
        check("ovr_valid_stays_low", rx_valid, 0);

        // Reset mid-frame with a pending frame
        start_frame(8'h24, 8'h24);
        run(FLEN);
        en = 1'b0;
        tick();
        check("rst_pre_valid", rx_valid, 1);
        start_frame(8'h99, 8'h99);
        run(150);
        rst = 1'b1;
        tick();
        check("rst_data",    rx_data,  0);
        check("rst_valid",   rx_valid, 0);
        check("rst_done",    rx_done,  0);
        check("rst_overrun", overrun,  0);
        rst = 1'b0; en = 1'b0;
        tick();
        check("rst_idle", dut.state_q, ST_IDLE);
        done_cnt = 0; rx_ready = 1'b1;
        start_frame(8'h81, 8'h81);
        run(FLEN);
        check("rst_after_done", rx_done, 1);
        check("rst_after_data", rx_data, 8'h81);
        en = 1'b0;
        tick();
        check("rst_after_count", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
